// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM driver with a prescaled period counter and double-buffered duty values.
// Optional macro PWM_PHASE_EN staggers the green and blue phases by 85 and 170 counts.
module rgb_pwm_driver #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] colour,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        period_start
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    shadow_q [3];
    logic [7:0]    shadow_d [3];
    logic [2:0]    pwm_q, pwm_d;
    logic          period_start_q, period_start_d;

    logic [7:0]    field [3];
    logic [7:0]    phase [3];
    logic          tick;
    logic          wrap;

    // Channel index 0 = red, 1 = green, 2 = blue.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
`ifdef PWM_PHASE_EN
        localparam logic [7:0] PHASE_OFF = 8'(85 * gi);
`else
        localparam logic [7:0] PHASE_OFF = 8'd0;
`endif
        assign field[gi] = colour[8*(2-gi) +: 8];
        assign phase[gi] = cnt_q + PHASE_OFF;
    end

    assign tick = (presc_q == PW'(PRESCALE - 1));
    assign wrap = tick && (cnt_q == 8'hFF);

    always_comb begin
        presc_d        = presc_q;
        cnt_d          = cnt_q;
        pwm_d          = '0;
        period_start_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            shadow_d[i] = shadow_q[i];
        end

        if (!en) begin
            // Disabled: hold the counters at the start of a period and keep shadows tracking colour.
            presc_d = '0;
            cnt_d   = '0;
            for (int i = 0; i < 3; i++) begin
                shadow_d[i] = field[i];
            end
        end else begin
            presc_d        = tick ? '0 : presc_q + 1'b1;
            cnt_d          = tick ? cnt_q + 8'd1 : cnt_q;
            period_start_d = wrap;
            for (int i = 0; i < 3; i++) begin
                pwm_d[i] = (phase[i] < shadow_q[i]) || (shadow_q[i] == 8'hFF);
                if (wrap) begin
                    shadow_d[i] = field[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            for (int i = 0; i < 3; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign pwm_r        = pwm_q[0];
    assign pwm_g        = pwm_q[1];
    assign pwm_b        = pwm_q[2];
    assign period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: two instances (PRESCALE 1 and 4) checked every cycle against a
// time-based model, plus directed duty/latency measurements and randomized stimulus.
module tb_rgb_pwm_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [23:0] colour = '0;
    logic        pwm_r1, pwm_g1, pwm_b1, ps1;
    logic        pwm_r4, pwm_g4, pwm_b4, ps4;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(1)) dut_p1 (
        .clk(clk), .rst(rst_n), .en(en), .colour(colour),
        .pwm_r(pwm_r1), .pwm_g(pwm_g1), .pwm_b(pwm_b1), .period_start(ps1)
    );

    rgb_pwm_driver #(.PRESCALE(4)) dut_p4 (
        .clk(clk), .rst(rst_n), .en(en), .colour(colour),
        .pwm_r(pwm_r4), .pwm_g(pwm_g4), .pwm_b(pwm_b4), .period_start(ps4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
`ifdef PWM_PHASE_EN
    localparam int unsigned OFFS [3] = '{0, 85, 170};
`else
    localparam int unsigned OFFS [3] = '{0, 0, 0};
`endif
    localparam int unsigned PS [2] = '{1, 4};

    // t = clocks elapsed in the current period since enable; count = t / p.
    function automatic logic [2:0] model_pwm(input int unsigned t, input int unsigned p,
                                             input logic [23:0] sh);
        int unsigned c = (t / p) % 256;
        logic [2:0] r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            int unsigned duty = (sh >> (8 * (2 - ch))) & 24'hFF;
            int unsigned ph   = (c + OFFS[ch]) % 256;
            r[2-ch] = (duty == 255) || (ph < duty);
        end
        return r;
    endfunction

    function automatic bit is_wrap(input int unsigned t, input int unsigned p);
        return (t % (256 * p)) == (256 * p - 1);
    endfunction

    int unsigned mt [2];
    logic [23:0] msh [2];
    logic [2:0]  exp_pwm [2];
    logic        exp_ps [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mt[d] <= 0; msh[d] <= '0; exp_pwm[d] <= '0; exp_ps[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!en) begin
                    mt[d] <= 0; msh[d] <= colour; exp_pwm[d] <= '0; exp_ps[d] <= 1'b0;
                end else begin
                    exp_pwm[d] <= model_pwm(mt[d], PS[d], msh[d]);
                    exp_ps[d]  <= is_wrap(mt[d], PS[d]);
                    if (is_wrap(mt[d], PS[d])) msh[d] <= colour;
                    mt[d] <= (mt[d] + 1) % (256 * PS[d]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_eq("cyc_rgb_p1", {29'd0, pwm_r1, pwm_g1, pwm_b1}, {29'd0, exp_pwm[0]});
            check_eq("cyc_ps_p1",  {31'd0, ps1}, {31'd0, exp_ps[0]});
            check_eq("cyc_rgb_p4", {29'd0, pwm_r4, pwm_g4, pwm_b4}, {29'd0, exp_pwm[1]});
            check_eq("cyc_ps_p4",  {31'd0, ps4}, {31'd0, exp_ps[1]});
        end
    end

    // ---------------- helpers ----------------
    task automatic load_and_enable(input logic [23:0] c);
        @(negedge clk); en = 1'b0; colour = c;
        repeat (3) @(negedge clk);
        en = 1'b1;
    endtask

    // Optionally wait for a period_start, then count high samples over one full period.
    task automatic count_period(input int d, input bit wait_first, input int change_at,
                                input logic [23:0] new_col,
                                output int hr, output int hg, output int hb, output int nps);
        int unsigned p = PS[d];
        bit seen = !wait_first;
        for (int i = 0; i < 2 * 256 * int'(p) + 8 && !seen; i++) begin
            @(negedge clk);
            seen = (d == 0) ? ps1 : ps4;
        end
        if (wait_first) check_eq("wait_ps", {31'd0, seen}, 32'd1);
        hr = 0; hg = 0; hb = 0; nps = 0;
        for (int i = 0; i < 256 * int'(p); i++) begin
            @(negedge clk);
            if (i == change_at) colour = new_col;
            hr  += int'((d == 0) ? pwm_r1 : pwm_r4);
            hg  += int'((d == 0) ? pwm_g1 : pwm_g4);
            hb  += int'((d == 0) ? pwm_b1 : pwm_b4);
            nps += int'((d == 0) ? ps1 : ps4);
        end
    endtask

    initial begin
        int hr, hg, hb, nps, lat;
        bit seen;

        // Reset held with en=1 and full white: everything stays dark.
        #3 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        en = 1'b1; colour = 24'hFFFFFF;
        repeat (5) @(negedge clk);
        check_eq("rst_outs", {24'd0, pwm_r1, pwm_g1, pwm_b1, ps1, pwm_r4, pwm_g4, pwm_b4, ps4}, 32'd0);
        #2 rst_n = 1'b1;
        $display("reset: released with en=1, colour=FFFFFF");
        repeat (300) @(negedge clk);

        // Duty extremes and half duty at PRESCALE=1.
        load_and_enable(24'h8000FF);
        count_period(0, 1'b1, -1, 24'h0, hr, hg, hb, nps);
        $display("8000FF: r=%0d g=%0d b=%0d ps=%0d", hr, hg, hb, nps);
        check_eq("r_half", hr, 128);
        check_eq("g_zero", hg, 0);
        check_eq("b_full", hb, 256);
        check_eq("ps_once", nps, 1);

        // Colour change mid-period only takes effect next period.
        load_and_enable(24'h100000);
        count_period(0, 1'b1, 49, 24'hF00000, hr, hg, hb, nps);
        $display("R10 then F0 mid-period: this period r=%0d", hr);
        check_eq("r_old_duty", hr, 16);
        count_period(0, 1'b0, -1, 24'h0, hr, hg, hb, nps);
        $display("R F0 next period: r=%0d ps=%0d", hr, nps);
        check_eq("r_new_duty", hr, 240);
        check_eq("ps_once2", nps, 1);

        // Disable mid-period, then re-enable and measure first period_start latency.
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin @(negedge clk); seen = ps1; end
        check_eq("wait_ps_dis", {31'd0, seen}, 32'd1);
        repeat (100) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check_eq("dis_dark", {28'd0, pwm_r1, pwm_g1, pwm_b1, ps1}, 32'd0);
        repeat (2) @(negedge clk);
        en = 1'b1;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin @(negedge clk); lat++; seen = ps1; end
        $display("re-enable: first period_start after %0d clocks", lat);
        check_eq("reen_latency", lat, 256);

        // PRESCALE=4 instance: 1024-clock period, R=0x40 -> 256 high clocks.
        load_and_enable(24'h400000);
        count_period(1, 1'b1, -1, 24'h0, hr, hg, hb, nps);
        $display("P4 R40: r=%0d ps=%0d", hr, nps);
        check_eq("p4_r_duty", hr, 256);
        check_eq("p4_ps_once", nps, 1);

`ifdef PWM_PHASE_EN
        begin
            int rr = -1, rg = -1, rb = -1;
            logic pr, pg, pb;
            load_and_enable(24'h808080);
            count_period(0, 1'b1, -1, 24'h0, hr, hg, hb, nps);
            pr = pwm_r1; pg = pwm_g1; pb = pwm_b1;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (pwm_r1 && !pr && rr < 0) rr = i;
                if (pwm_g1 && !pg && rg < 0) rg = i;
                if (pwm_b1 && !pb && rb < 0) rb = i;
                pr = pwm_r1; pg = pwm_g1; pb = pwm_b1;
            end
            $display("phase 808080: rise r=%0d g=%0d b=%0d highs %0d/%0d/%0d", rr, rg, rb, hr, hg, hb);
            check_eq("phase_g", rg - rr, 171);
            check_eq("phase_b", rb - rr, 86);
            check_eq("phase_highs", hr + hg + hb, 384);
        end
`endif

        // Reset mid-operation clears everything asynchronously.
        load_and_enable(24'hFFFFFF);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst", {24'd0, pwm_r1, pwm_g1, pwm_b1, ps1, pwm_r4, pwm_g4, pwm_b4, ps4}, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        $display("mid-run reset applied and released");

        // Randomized colours, enable toggles and occasional resets against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) colour = 24'($urandom);
            if ($urandom_range(0, 299) == 0) en = ~en;
            if ($urandom_range(0, 1499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk); #2 rst_n = 1'b1;
            end
        end
        $display("random: 4000 cycles done");

        @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
